// File: rtl/irq_controller.sv
// irq_controller: vectored interrupt controller feeding the branch/exception unit.
// Raw lines are synchronised and latched into a pending register, either as
// rising-edge events or as sampled levels. Unmasked pending lines are arbitrated
// by fixed priority (lowest index wins). A three-state FSM presents one request
// and tracks it through acknowledge and end-of-interrupt.
module irq_controller #(
    parameter int                 NUM_IRQ   = 8,
    parameter int                 ID_W      = 3,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1,
    parameter logic [NUM_IRQ-1:0] MASK_RST  = '1,
    parameter logic [31:0]        VEC_BASE  = 32'h0000_0010,
    parameter int                 VEC_SHIFT = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_in_i,
    input  logic               mask_wr_i,
    input  logic [NUM_IRQ-1:0] mask_data_i,
    input  logic               int_ack_i,
    input  logic               eoi_i,
    output logic               int_req_o,
    output logic [ID_W-1:0]    int_id_o,
    output logic [31:0]        int_addr_o,
    output logic               in_service_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_IRQ-1:0] s1_q, s2_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [2**ID_W-1:0] elig_ext;
    logic [ID_W-1:0]    win_id;
    logic               any_elig;
    logic               ack_fire;

    // An acknowledge only counts while a request is actually being presented.
    assign ack_fire = (state_q == ST_REQ) && int_ack_i;

    // Two-flop synchroniser for every raw line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= irq_in_i;
            s2_q <= s1_q;
        end
    end

    // Mask register; a write is visible to arbitration from the next cycle on.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= MASK_RST;
        end else if (mask_wr_i) begin
            mask_q <= mask_data_i;
        end
    end

    // Per-line pending next state: edge lines latch rising edges, level lines follow s2.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            assign ack_clr[gi] = ack_fire && (id_q == ID_W'(gi));
            if (EDGE_MASK[gi]) begin : g_edge
                logic s3_q;
                logic rise;

                // Delayed copy of the synchronised line for edge detection.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        s3_q <= 1'b0;
                    end else begin
                        s3_q <= s2_q[gi];
                    end
                end

                assign rise = s2_q[gi] & ~s3_q;
                // A new edge arriving on the clearing cycle must not be lost, so set wins.
                assign pending_d[gi] = rise | (pending_q[gi] & ~ack_clr[gi]);
            end else begin : g_level
                assign pending_d[gi] = s2_q[gi];
            end
        end
    endgenerate

    // Pending register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign eligible = pending_q & ~mask_q;
    assign any_elig = |eligible;

    // Fixed-priority arbitration: scan from the top so the lowest index wins.
    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Eligibility widened to the full ID space so the latched ID can index it safely.
    always_comb begin
        elig_ext                = '0;
        elig_ext[NUM_IRQ-1:0]   = eligible;
    end

    // FSM state and latched ID registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // FSM next state; the ID only changes when a new request is started from IDLE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    id_d    = win_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Acknowledge takes precedence over a simultaneous withdrawal.
                if (int_ack_i) begin
                    state_d = ST_SVC;
                end else if (!elig_ext[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (eoi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign int_req_o    = (state_q == ST_REQ);
    assign in_service_o = (state_q == ST_SVC);
    assign int_id_o     = id_q;
    assign pending_o    = pending_q;
    assign int_addr_o   = VEC_BASE + ({{(32 - ID_W){1'b0}}, id_q} << VEC_SHIFT);

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: line 4 is level-sensitive, all others edge,
// mask resets to zero. Expected request IDs go into a scoreboard queue when
// the interrupt is stimulated and are compared when the DUT raises IntReq.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        mask_wr;
    logic [7:0]  mask_data;
    logic        int_ack;
    logic        eoi;
    logic        int_req;
    logic [2:0]  int_id;
    logic [31:0] int_addr;
    logic        in_service;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    irq_controller #(
        .NUM_IRQ  (8),
        .ID_W     (3),
        .EDGE_MASK(8'hEF),
        .MASK_RST (8'h00),
        .VEC_BASE (32'h0000_0010),
        .VEC_SHIFT(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_in_i    (irq),
        .mask_wr_i   (mask_wr),
        .mask_data_i (mask_data),
        .int_ack_i   (int_ack),
        .eoi_i       (eoi),
        .int_req_o   (int_req),
        .int_id_o    (int_id),
        .int_addr_o  (int_addr),
        .in_service_o(in_service),
        .pending_o   (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_irq(input logic [7:0] lines);
        irq = irq | lines;
        tick();
        irq = irq & ~lines;
    endtask

    task automatic write_mask(input logic [7:0] value);
        mask_wr   = 1'b1;
        mask_data = value;
        tick();
        mask_wr   = 1'b0;
    endtask

    // Wait (bounded) for IntReq, pop the scoreboard and compare ID and vector.
    task automatic check_req();
        bit seen;
        int exp;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (int_req === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL req_timeout: int_req=%0b after 20 cycles, required 1", int_req);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: request id=%0d seen with no expected entry", int_id);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (int_id !== 3'(exp)) begin
            errors++;
            $display("FAIL req_id: got %0d, required %0d", int_id, exp);
        end
        checks++;
        if (int_addr !== 32'h10 + 32'(exp * 4)) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", int_addr, 32'h10 + 32'(exp * 4));
        end
        $display("request id=%0d addr=%h (expected id=%0d)", int_id, int_addr, exp);
    endtask

    task automatic do_ack(input int id);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (in_service !== 1'b1 || int_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_state: in_service=%0b int_req=%0b, required 1 0", in_service, int_req);
        end
        checks++;
        if (int_id !== 3'(id) || pending[id] !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: id=%0d pending=%b, required id=%0d with bit clear", int_id, pending, id);
        end
        $display("ack id=%0d in_service=%0b pending=%b", int_id, in_service, pending);
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        checks++;
        if (in_service !== 1'b0) begin
            errors++;
            $display("FAIL eoi: in_service=%0b, required 0", in_service);
        end
        $display("eoi in_service=%0b", in_service);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (int_req !== 1'b0 || in_service !== 1'b0 || pending !== 8'h00 ||
            int_id !== 3'd0 || int_addr !== 32'h10) begin
            errors++;
            $display("FAIL reset_state: req=%0b svc=%0b pend=%h id=%0d addr=%h, required 0 0 00 0 00000010",
                     int_req, in_service, pending, int_id, int_addr);
        end
        rst = 1'b0;
        tick();
        // Exact latency: line 3 high before edge k, pending at k+2, request after k+3.
        irq[3] = 1'b1;
        tick();
        irq[3] = 1'b0;
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("FAIL lat_k: pending=%h, required 00", pending);
        end
        tick();
        tick();
        checks++;
        if (pending !== 8'h08 || int_req !== 1'b0) begin
            errors++;
            $display("FAIL lat_k2: pending=%h int_req=%0b, required 08 0", pending, int_req);
        end
        exp_q.push_back(3);
        tick();
        checks++;
        if (int_req !== 1'b1) begin
            errors++;
            $display("FAIL lat_k3: int_req=%0b, required 1", int_req);
        end
        check_req();
        do_ack(3);
        do_eoi();
        repeat (2) tick();
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_eoi: int_req=%0b, required 0", int_req);
        end
        // Acknowledge while idle must not start service.
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (in_service !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: in_service=%0b, required 0", in_service);
        end
    endtask

    task automatic test_priority();
        exp_q.push_back(2);
        exp_q.push_back(5);
        pulse_irq(8'h24);
        check_req();
        do_ack(2);
        checks++;
        if (pending[5] !== 1'b1) begin
            errors++;
            $display("FAIL prio_keep5: pending=%h, required bit5 set", pending);
        end
        do_eoi();
        check_req();
        // EOI while a request is outstanding is ignored.
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd5) begin
            errors++;
            $display("FAIL stray_eoi: int_req=%0b id=%0d, required 1 5", int_req, int_id);
        end
        do_ack(5);
        do_eoi();
    endtask

    task automatic test_mask();
        write_mask(8'h02);
        pulse_irq(8'h02);
        repeat (6) tick();
        checks++;
        if (int_req !== 1'b0 || pending[1] !== 1'b1) begin
            errors++;
            $display("FAIL masked: int_req=%0b pending=%h, required 0 with bit1 set", int_req, pending);
        end
        write_mask(8'h00);
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("FAIL unmask_early: int_req=%0b, required 0", int_req);
        end
        exp_q.push_back(1);
        tick();
        checks++;
        if (int_req !== 1'b1) begin
            errors++;
            $display("FAIL unmask_lat: int_req=%0b, required 1", int_req);
        end
        check_req();
        do_ack(1);
        do_eoi();
    endtask

    task automatic test_level_withdraw();
        irq[4] = 1'b1;
        exp_q.push_back(4);
        check_req();
        checks++;
        if (pending[4] !== 1'b1) begin
            errors++;
            $display("FAIL level_pend: pending=%h, required bit4 set", pending);
        end
        irq[4] = 1'b0;
        repeat (3) tick();
        checks++;
        if (int_req !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_early: int_req=%0b, required 1", int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b0 || in_service !== 1'b0 || pending[4] !== 1'b0) begin
            errors++;
            $display("FAIL withdraw: req=%0b svc=%0b pending=%h, required 0 0 bit4 clear",
                     int_req, in_service, pending);
        end
        repeat (5) tick();
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_idle: int_req=%0b, required 0", int_req);
        end
        $display("withdraw line 4 req=%0b svc=%0b", int_req, in_service);
    endtask

    task automatic test_simultaneous();
        exp_q.push_back(0);
        pulse_irq(8'h01);
        check_req();
        // New edge lands in pending on the same clock as the acknowledge clear.
        irq[0] = 1'b1;
        tick();
        irq[0] = 1'b0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (in_service !== 1'b1 || pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: in_service=%0b pending=%h, required 1 with bit0 set", in_service, pending);
        end
        $display("ack id=%0d with concurrent edge pending=%b", int_id, pending);
        exp_q.push_back(0);
        do_eoi();
        check_req();
        do_ack(0);
        do_eoi();
    endtask

    task automatic test_async_reset();
        exp_q.push_back(6);
        exp_q.push_back(7);
        pulse_irq(8'hC0);
        check_req();
        do_ack(6);
        checks++;
        if (pending[7] !== 1'b1) begin
            errors++;
            $display("FAIL pend7: pending=%h, required bit7 set", pending);
        end
        write_mask(8'hFF);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_service !== 1'b0 || int_req !== 1'b0 || pending !== 8'h00 || int_addr !== 32'h10) begin
            errors++;
            $display("FAIL async_reset: svc=%0b req=%0b pend=%h addr=%h, required 0 0 00 00000010",
                     in_service, int_req, pending, int_addr);
        end
        exp_q.delete();
        $display("async reset svc=%0b req=%0b pending=%h", in_service, int_req, pending);
        tick();
        rst = 1'b0;
        tick();
        // Mask must be back at its reset value (all unmasked).
        exp_q.push_back(5);
        pulse_irq(8'h20);
        check_req();
        do_ack(5);
        do_eoi();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        irq       = 8'h00;
        mask_wr   = 1'b0;
        mask_data = 8'h00;
        int_ack   = 1'b0;
        eoi       = 1'b0;
        tick();
        test_reset();
        test_priority();
        test_mask();
        test_level_withdraw();
        test_simultaneous();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
